// File: rtl/nn_mem_responder.sv
// Avalon-style 16-bit memory slave with a fixed per-access stall, a fixed-latency pipelined
// read return, saturating access counters and a sticky master-protocol violation flag.
module nn_mem_responder #(
  parameter int          DEPTH_LOG2   = 10,
  parameter logic [31:0] BASE         = 32'd0,
  parameter int          WAIT_CYCLES  = 2,
  parameter int          READ_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic [1:0]  byteenable,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] address,
  input  logic [15:0] writedata,
  output logic        waitrequest,
  output logic        readdatavalid,
  output logic [15:0] readdata,
  output logic [15:0] read_count,
  output logic [15:0] write_count,
  output logic        protocol_err
);

  localparam logic [3:0]  LP_WC    = 4'(WAIT_CYCLES);
  localparam int          LP_WORDS = 1 << DEPTH_LOG2;
  localparam logic [32:0] LP_SPAN  = 33'(2 * LP_WORDS);

  typedef enum logic {S_IDLE, S_STALL} state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_scnt, w_scnt_next;
  logic [31:0] r_addr;
  logic        r_read_n, r_write_n;

  logic        w_req, w_viol, w_accept, w_both, w_err_set;
  logic        w_acc_rd, w_acc_wr;
  logic [32:0] w_off;
  logic        w_in_range;
  logic [DEPTH_LOG2-1:0] w_idx;

  logic [15:0] r_mem   [LP_WORDS];
  logic [15:0] r_pdata [READ_LATENCY];
  logic        r_pvld  [READ_LATENCY];

  assign w_req  = chipselect & (~read_n | ~write_n);
  assign w_both = ~read_n & ~write_n;

  // The master must hold the request stable for the whole stall.
  assign w_viol = (r_state == S_STALL) &
                  (~w_req | (address != r_addr) | (read_n != r_read_n) | (write_n != r_write_n));

  assign w_err_set = w_viol | (w_accept & w_both);
  assign w_acc_rd  = reset_n & w_accept & ~read_n & write_n;
  assign w_acc_wr  = reset_n & w_accept & read_n & ~write_n;

  assign w_off      = {1'b0, address} - {1'b0, BASE};
  assign w_in_range = ~w_off[32] & (w_off < LP_SPAN);
  assign w_idx      = w_off[DEPTH_LOG2:1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_scnt  <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_scnt  <= w_scnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_scnt_next  = r_scnt;
    case (r_state)
      S_IDLE: begin
        w_scnt_next = 4'd0;
        if ((LP_WC != 4'd0) && w_req) begin
          w_state_next = S_STALL;
          w_scnt_next  = 4'd1;
        end
      end
      S_STALL: begin
        if (w_viol || (r_scnt == LP_WC)) begin
          w_state_next = S_IDLE;
          w_scnt_next  = 4'd0;
        end else begin
          w_scnt_next = r_scnt + 4'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_scnt_next  = 4'd0;
      end
    endcase
  end

  always_comb begin
    waitrequest = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        waitrequest = (LP_WC != 4'd0) & w_req;
        w_accept    = (LP_WC == 4'd0) & w_req;
      end
      S_STALL: begin
        waitrequest = (r_scnt < LP_WC);
        w_accept    = ~w_viol & (r_scnt == LP_WC);
      end
      default: ;
    endcase
  end

  // Snapshot of the request while idle, compared against during the stall.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE) begin
      r_addr    <= address;
      r_read_n  <= read_n;
      r_write_n <= write_n;
    end
  end

  // Memory and read-data pipeline carry no reset so contents survive it.
  always_ff @(posedge clk) begin
    if (w_acc_wr && w_in_range) begin
      for (int b = 0; b < 2; b++) begin
        if (byteenable[b]) r_mem[w_idx][b*8 +: 8] <= writedata[b*8 +: 8];
      end
    end
    if (w_acc_rd) r_pdata[0] <= w_in_range ? r_mem[w_idx] : 16'hDEAD;
    for (int i = READ_LATENCY - 1; i > 0; i--) r_pdata[i] <= r_pdata[i-1];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) r_pvld[i] <= 1'b0;
      readdatavalid <= 1'b0;
      readdata      <= 16'd0;
      read_count    <= 16'd0;
      write_count   <= 16'd0;
      protocol_err  <= 1'b0;
    end else begin
      r_pvld[0] <= w_acc_rd;
      for (int i = READ_LATENCY - 1; i > 0; i--) r_pvld[i] <= r_pvld[i-1];
      readdatavalid <= r_pvld[READ_LATENCY-1];
      if (r_pvld[READ_LATENCY-1]) readdata <= r_pdata[READ_LATENCY-1];
      if (w_acc_rd && (read_count != 16'hFFFF)) read_count <= read_count + 16'd1;
      if (w_acc_wr && (write_count != 16'hFFFF)) write_count <= write_count + 16'd1;
      if (w_err_set) protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nn_mem_responder.sv
// Scoreboard bench: stimulus pushes expected read responses with their due cycle,
// per-DUT monitors compare readdatavalid/readdata against the queue every cycle.
module tb_nn_mem_responder;
  localparam int RL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] d;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  bit   mon_en  = 1'b0;

  // DUT A: default parameters
  logic        a_rstn, a_cs, a_rdn, a_wrn;
  logic [1:0]  a_be;
  logic [31:0] a_addr;
  logic [15:0] a_wd;
  logic        a_wait, a_rdv, a_perr;
  logic [15:0] a_rdata, a_rc, a_wc;

  // DUT B: zero wait states
  logic        b_rstn, b_cs, b_rdn, b_wrn;
  logic [1:0]  b_be;
  logic [31:0] b_addr;
  logic [15:0] b_wd;
  logic        b_wait, b_rdv, b_perr;
  logic [15:0] b_rdata, b_rc, b_wc;

  nn_mem_responder u_a (
    .clk(clk), .reset_n(a_rstn), .chipselect(a_cs), .byteenable(a_be),
    .read_n(a_rdn), .write_n(a_wrn), .address(a_addr), .writedata(a_wd),
    .waitrequest(a_wait), .readdatavalid(a_rdv), .readdata(a_rdata),
    .read_count(a_rc), .write_count(a_wc), .protocol_err(a_perr)
  );

  nn_mem_responder #(.WAIT_CYCLES(0), .READ_LATENCY(RL)) u_b (
    .clk(clk), .reset_n(b_rstn), .chipselect(b_cs), .byteenable(b_be),
    .read_n(b_rdn), .write_n(b_wrn), .address(b_addr), .writedata(b_wd),
    .waitrequest(b_wait), .readdatavalid(b_rdv), .readdata(b_rdata),
    .read_count(b_rc), .write_count(b_wc), .protocol_err(b_perr)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  always @(negedge clk) begin
    bit   exp_v;
    exp_t e;
    if (mon_en) begin
      exp_v = (qa.size() > 0) && (qa[0].due == cyc);
      chk("a_readdatavalid", a_rdv, exp_v);
      if (exp_v) begin
        e = qa.pop_front();
        chk("a_readdata", a_rdata, e.d);
      end
    end
  end

  always @(negedge clk) begin
    bit   exp_v;
    exp_t e;
    if (mon_en) begin
      exp_v = (qb.size() > 0) && (qb[0].due == cyc);
      chk("b_readdatavalid", b_rdv, exp_v);
      if (exp_v) begin
        e = qb.pop_front();
        chk("b_readdata", b_rdata, e.d);
      end
    end
  end

  // One access on DUT A; returns 1 time unit after the acceptance edge.
  task automatic acc_a(input logic rdn, input logic wrn, input logic [31:0] addr,
                       input logic [15:0] wd, input logic [1:0] be,
                       input logic [15:0] ex, input bit push);
    int stalls;
    bit done;
    stalls = 0;
    done   = 1'b0;
    a_cs = 1'b1; a_rdn = rdn; a_wrn = wrn; a_addr = addr; a_wd = wd; a_be = be;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (a_wait) stalls++;
      else begin
        done = 1'b1;
        if (!rdn && wrn && push) qa.push_back('{ex, cyc + 1 + RL});
      end
    end
    chk("a_accepted", done, 1);
    chk("a_stall_cycles", stalls, 2);
    $display("A rd_n=%0b wr_n=%0b addr=%08h wd=%04h be=%02b exp_rd=%04h stalls=%0d",
             rdn, wrn, addr, wd, be, ex, stalls);
    @(posedge clk);
    #1;
    a_cs = 1'b0; a_rdn = 1'b1; a_wrn = 1'b1; a_be = 2'b00;
  endtask

  task automatic rst_a();
    a_rstn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    a_rstn = 1'b1;
  endtask

  logic [15:0] bv [3];

  initial begin
    bv = '{16'h0101, 16'h0202, 16'h0303};
    a_rstn = 1'b0; a_cs = 1'b0; a_rdn = 1'b1; a_wrn = 1'b1; a_be = 2'b00; a_addr = '0; a_wd = '0;
    b_rstn = 1'b0; b_cs = 1'b0; b_rdn = 1'b1; b_wrn = 1'b1; b_be = 2'b00; b_addr = '0; b_wd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_waitrequest", a_wait, 0);
    chk("rst_readdatavalid", a_rdv, 0);
    chk("rst_readdata", a_rdata, 0);
    chk("rst_read_count", a_rc, 0);
    chk("rst_write_count", a_wc, 0);
    chk("rst_protocol_err", a_perr, 0);
    @(posedge clk);
    #1;
    a_rstn = 1'b1; b_rstn = 1'b1;
    mon_en = 1'b1;

    // basic write then read
    acc_a(1, 0, 32'h10, 16'h1234, 2'b11, 16'h0, 1);
    acc_a(0, 1, 32'h10, 16'h0, 2'b00, 16'h1234, 1);
    chk("a_wc_1", a_wc, 1);
    chk("a_rc_1", a_rc, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("a_readdata_hold", a_rdata, 16'h1234);

    // byte lanes
    acc_a(1, 0, 32'h10, 16'hABCD, 2'b01, 16'h0, 1);
    acc_a(0, 1, 32'h10, 16'h0, 2'b00, 16'h12CD, 1);
    acc_a(1, 0, 32'h10, 16'hFFFF, 2'b00, 16'h0, 1);
    acc_a(0, 1, 32'h10, 16'h0, 2'b00, 16'h12CD, 1);
    chk("a_wc_3", a_wc, 3);
    chk("a_rc_3", a_rc, 3);

    // range boundary
    acc_a(1, 0, 32'h0, 16'h0A0B, 2'b11, 16'h0, 1);
    acc_a(1, 0, 32'h800, 16'h5555, 2'b11, 16'h0, 1);
    acc_a(0, 1, 32'h0, 16'h0, 2'b00, 16'h0A0B, 1);
    acc_a(0, 1, 32'h800, 16'h0, 2'b00, 16'hDEAD, 1);
    acc_a(1, 0, 32'h7FE, 16'h7777, 2'b11, 16'h0, 1);
    acc_a(0, 1, 32'h7FE, 16'h0, 2'b00, 16'h7777, 1);
    chk("a_wc_6", a_wc, 6);
    chk("a_rc_6", a_rc, 6);

    // read-after-write ordering, address bit 0 ignored
    acc_a(1, 0, 32'h20, 16'h1111, 2'b11, 16'h0, 1);
    acc_a(0, 1, 32'h20, 16'h0, 2'b00, 16'h1111, 1);
    acc_a(1, 0, 32'h20, 16'h2222, 2'b11, 16'h0, 1);
    acc_a(0, 1, 32'h20, 16'h0, 2'b00, 16'h2222, 1);
    acc_a(0, 1, 32'h21, 16'h0, 2'b00, 16'h2222, 1);
    chk("a_wc_8", a_wc, 8);
    chk("a_rc_9", a_rc, 9);
    chk("a_perr_clean", a_perr, 0);

    // both read_n and write_n low
    acc_a(0, 0, 32'h10, 16'h9999, 2'b11, 16'h0, 1);
    chk("a_perr_both_low", a_perr, 1);
    chk("a_wc_unchanged", a_wc, 8);
    chk("a_rc_unchanged", a_rc, 9);
    acc_a(0, 1, 32'h10, 16'h0, 2'b00, 16'h12CD, 1);
    chk("a_perr_sticky", a_perr, 1);
    repeat (5) @(posedge clk);
    #1;
    rst_a();
    chk("a_perr_after_rst", a_perr, 0);
    chk("a_rc_after_rst", a_rc, 0);
    acc_a(0, 1, 32'h10, 16'h0, 2'b00, 16'h12CD, 1);

    // withdraw request mid-stall
    a_cs = 1'b1; a_rdn = 1'b0; a_wrn = 1'b1; a_addr = 32'h10;
    @(negedge clk);
    chk("a_wait_first_cycle", a_wait, 1);
    @(posedge clk);
    #1;
    a_cs = 1'b0; a_rdn = 1'b1;
    $display("A read 00000010 withdrawn during stall");
    repeat (3) @(posedge clk);
    #1;
    chk("a_perr_withdraw", a_perr, 1);
    chk("a_rc_withdraw", a_rc, 1);

    // reset one cycle after read acceptance
    acc_a(1, 0, 32'h30, 16'hBEEF, 2'b11, 16'h0, 1);
    acc_a(0, 1, 32'h30, 16'h0, 2'b00, 16'h0, 0);
    a_rstn = 1'b0;
    @(posedge clk);
    #1;
    a_rstn = 1'b1;
    chk("a_rc_mid_rst", a_rc, 0);
    chk("a_wc_mid_rst", a_wc, 0);
    chk("a_perr_mid_rst", a_perr, 0);
    repeat (6) @(posedge clk);
    #1;
    acc_a(0, 1, 32'h30, 16'h0, 2'b00, 16'hBEEF, 1);

    // DUT B: zero-wait writes then back-to-back reads
    for (int i = 0; i < 6; i++) begin
      b_cs = 1'b1; b_be = 2'b11;
      if (i < 3) begin
        b_rdn = 1'b1; b_wrn = 1'b0; b_addr = 32'(2 * i); b_wd = bv[i];
      end else begin
        b_rdn = 1'b0; b_wrn = 1'b1; b_addr = 32'(2 * (i - 3)); b_wd = 16'h0;
      end
      @(negedge clk);
      chk("b_waitrequest", b_wait, 0);
      if (i >= 3) qb.push_back('{bv[i-3], cyc + 1 + RL});
      $display("B %s addr=%08h data=%04h", (i < 3) ? "wr" : "rd", b_addr, (i < 3) ? b_wd : bv[i-3]);
      @(posedge clk);
      #1;
    end
    b_cs = 1'b0; b_rdn = 1'b1; b_wrn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("b_rc", b_rc, 3);
    chk("b_wc", b_wc, 3);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/nn_mem_responder.md
NN_MEM_RESPONDER -- requirements
Module: nn_mem_responder

Interface
Parameters:
REQ-001 The module SHALL have parameter DEPTH_LOG2, default 10, giving log2 of the number of 16-bit words in the memory.
REQ-002 The module SHALL have parameter BASE, default 32'd0, giving the byte address of word 0.
REQ-003 The module SHALL have parameter WAIT_CYCLES, default 2, giving the stall cycles per access (range 0..15).
REQ-004 The module SHALL have parameter READ_LATENCY, default 3, giving the cycles from read acceptance to data (range 1..8).

Ports:
REQ-005 The module SHALL have the following ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- chipselect  in  1  request qualifier.
- byteenable  in  2  write lane enables; [1] = bits 15:8, [0] = bits 7:0.
- read_n  in  1  active-low read request.
- write_n  in  1  active-low write request.
- address  in  32  byte address; bit 0 ignored.
- writedata  in  16  write data.
- waitrequest  out  1  stall; a request is accepted on a cycle where it is present and waitrequest=0.
- readdatavalid  out  1  one-cycle pulse per accepted read.
- readdata  out  16  read data, valid when readdatavalid=1.
- read_count  out  16  accepted reads, saturating.
- write_count  out  16  accepted writes, saturating.
- protocol_err  out  1  sticky master-violation flag.

Function
REQ-006 A request SHALL be defined as req = chipselect & (~read_n | ~write_n).
REQ-007 The FSM SHALL have states IDLE and STALL, plus a 4-bit stall counter scnt.
REQ-008 IDLE, WAIT_CYCLES=0: waitrequest SHALL be 0, and a present req SHALL be accepted in the same cycle.
REQ-009 IDLE, WAIT_CYCLES>0, req=1: waitrequest SHALL be 1 (combinational), and the next state SHALL be STALL with scnt=1.
REQ-010 STALL: waitrequest SHALL be 1 while scnt<WAIT_CYCLES, with scnt incrementing each cycle.
REQ-011 STALL: when scnt==WAIT_CYCLES, waitrequest SHALL be 0, req SHALL be accepted, and the next state SHALL be IDLE.
REQ-012 Each access SHALL therefore see exactly WAIT_CYCLES cycles of waitrequest=1 before acceptance.
REQ-013 Back-to-back requests SHALL each incur the full stall.
REQ-014 If req drops or address/read_n/write_n change while in STALL, the FSM SHALL return to IDLE, perform no access, and set protocol_err.
REQ-015 If read_n=0 and write_n=0 simultaneously at acceptance, the request SHALL be accepted with no memory access, no readdatavalid, no count change, and protocol_err set.
REQ-016 In range SHALL be defined as BASE <= address < BASE + 2*2^DEPTH_LOG2; word index = (address-BASE)>>1.
REQ-017 An accepted write SHALL update, at the acceptance edge, only the lanes whose byteenable bit is 1.
REQ-018 A write with byteenable=2'b00 SHALL be counted but SHALL change no memory.
REQ-019 An accepted read SHALL sample the memory word at the acceptance edge, before any later write.
REQ-020 An accepted read SHALL push the sampled word into a READ_LATENCY-deep pipeline.
REQ-021 readdatavalid=1 and readdata=sampled word SHALL occur exactly READ_LATENCY cycles after the acceptance edge.
REQ-022 Reads SHALL return in acceptance order.
REQ-023 The read pipeline SHALL advance every cycle; there SHALL be no backpressure on the response path.
REQ-024 readdata SHALL hold its last value when readdatavalid=0.
REQ-025 An out-of-range write SHALL be dropped but counted.
REQ-026 An out-of-range read SHALL be counted and SHALL return 16'hDEAD with normal latency.
REQ-027 Write-then-read to the same address SHALL return the new data.
REQ-028 Read-then-write to the same address SHALL return the old data.
REQ-029 read_count and write_count SHALL increment by 1 per accepted read or write and SHALL saturate at 16'hFFFF (no wrap).
REQ-030 chipselect=0 SHALL cause the read_n/write_n inputs to be ignored.

Reset
REQ-031 When reset_n=0 at a clock edge, the block SHALL enter IDLE with scnt=0 and the read pipeline cleared (no pending readdatavalid).
REQ-032 Reset SHALL set waitrequest=0 (with reset_n low and req low), readdatavalid=0, readdata=0, read_count=0, write_count=0, and protocol_err=0.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 Reads in flight at reset SHALL be discarded and SHALL never produce readdatavalid.
REQ-035 protocol_err SHALL be cleared only by reset.

Verification
REQ-036 Default parameters, write 16'h1234 to 0x0010 with byteenable=11, then read 0x0010 -> each access sees waitrequest=1 for 2 cycles, then is accepted; readdatavalid pulses 3 cycles after read acceptance with readdata=16'h1234; write_count=1, read_count=1.
REQ-037 0x0010 holds 16'h1234; write 16'hABCD to 0x0010 with byteenable=01, then read -> 16'h12CD; byteenable=00 write -> data unchanged, write_count increments.
REQ-038 WAIT_CYCLES=0, READ_LATENCY=3, reads of 0x0,0x2,0x4 on consecutive cycles -> waitrequest stays 0; three consecutive readdatavalid pulses in order, the first 3 cycles after the first acceptance.
REQ-039 Read of 0x0800 (just past 1024 words) -> readdata=16'hDEAD after latency; write to 0x0800 -> memory unchanged, write_count increments.
REQ-040 read_n and write_n both low -> protocol_err=1 after acceptance, no readdatavalid; withdrawing req mid-STALL also sets protocol_err; only reset clears it.
REQ-041 Reset asserted one cycle after a read is accepted -> no readdatavalid afterward; counters 0; memory word still holds its pre-reset value on a subsequent read.
